// File: rtl/ct_pkg.sv
// Shared types and constants for the current-trigger event timer.
package ct_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_QUAL,
        S_MEAS,
        S_HOLDOFF
    } state_e;

    localparam int CW_DEFAULT = 8;
    localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/ct_event_timer_if.sv
// Host/comparator-side signal bundle of the event timer; slave = timer, master = host.
interface ct_event_timer_if
    import ct_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);
    logic          ena;
    logic          trig_in;
    logic          arm;
    logic          rd_ack;
    logic [CW-1:0] width_out;
    logic [CW-1:0] evt_cnt;
    logic          valid;
    logic          busy;
    logic          overflow;

    modport master (
        output ena, trig_in, arm, rd_ack,
        input  width_out, evt_cnt, valid, busy, overflow
    );

    modport slave (
        input  ena, trig_in, arm, rd_ack,
        output width_out, evt_cnt, valid, busy, overflow
    );
endinterface

// File: rtl/ct_evt_fifo.sv
// Small synchronous FIFO of captured widths; a pop and push in the same cycle
// always succeed, even when full.
module ct_evt_fifo
    import ct_pkg::*;
#(
    parameter int DW    = CW_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [AW-1:0]            wptr_q, rptr_q;
    logic [CNTW-1:0]          cnt_q;
    logic                     do_push, do_pop;

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            // When full, wptr == rptr: the slot being popped is reused as the new tail.
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + CNTW'(do_push) - CNTW'(do_pop);
        end
    end
endmodule

// File: rtl/ct_event_timer.sv
// Comparator pulse qualifier / width timer with valid/ack result handshake.
// Define CT_EVT_FIFO_EN to buffer results in a 4-entry FIFO instead of one register.
module ct_event_timer
    import ct_pkg::*;
#(
    parameter int MIN_W   = 3,
    parameter int HOLDOFF = 4,
    parameter int CW      = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    ct_event_timer_if.slave   bus
);
    logic          sync1_q, trig_s_q;
    state_e        state_q;
    logic [CW-1:0] wcnt_q;
    logic [3:0]    qcnt_q;
    logic [7:0]    hcnt_q;
    logic [CW-1:0] evt_q, evt_d;
    logic          ovf_q, ovf_d;
    logic          go_idle, cap;

    assign go_idle = !bus.ena || !bus.arm;
    assign cap     = (state_q == S_MEAS) && !trig_s_q && !go_idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            trig_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.trig_in;
            trig_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || go_idle) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            qcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_ARMED;
                S_ARMED: if (trig_s_q) begin
                    wcnt_q  <= CW'(1);
                    qcnt_q  <= 4'd1;
                    state_q <= (MIN_W == 1) ? S_MEAS : S_QUAL;
                end
                S_QUAL: if (!trig_s_q) begin
                    state_q <= S_ARMED;
                end else begin
                    if (wcnt_q != '1) wcnt_q <= wcnt_q + CW'(1);
                    qcnt_q <= qcnt_q + 4'd1;
                    if (qcnt_q + 4'd1 == 4'(MIN_W)) state_q <= S_MEAS;
                end
                S_MEAS: if (trig_s_q) begin
                    if (wcnt_q != '1) wcnt_q <= wcnt_q + CW'(1);
                end else begin
                    hcnt_q  <= '0;
                    state_q <= S_HOLDOFF;
                end
                S_HOLDOFF: if ({1'b0, hcnt_q} + 9'd1 >= 9'(HOLDOFF)) begin
                    state_q <= S_ARMED;
                end else begin
                    hcnt_q <= hcnt_q + 8'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CT_EVT_FIFO_EN
    logic          f_push, f_pop, f_full, f_empty;
    logic [CW-1:0] f_head;

    assign f_pop  = bus.rd_ack && !f_empty;
    assign f_push = cap && (!f_full || f_pop);

    ct_evt_fifo #(.DW(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .wdata_i (wcnt_q),
        .rdata_o (f_head),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    always_comb begin
        evt_d = evt_q;
        ovf_d = ovf_q;
        if (cap) begin
            evt_d = evt_q + CW'(1);
            if (f_full && !f_pop) ovf_d = 1'b1;
        end
        if (go_idle) begin
            evt_d = '0;
            ovf_d = 1'b0;
        end
    end

    assign bus.width_out = f_head;
    assign bus.valid     = !f_empty;
`else
    logic [CW-1:0] width_q, width_d;
    logic          valid_q, valid_d;

    always_comb begin
        evt_d   = evt_q;
        ovf_d   = ovf_q;
        width_d = width_q;
        valid_d = valid_q;
        if (bus.rd_ack && valid_q) valid_d = 1'b0;
        if (cap) begin
            evt_d = evt_q + CW'(1);
            if (!valid_q || bus.rd_ack) begin
                width_d = wcnt_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        // Result register survives an abort; counters and overflow do not.
        if (go_idle) begin
            evt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width_q <= '0;
            valid_q <= 1'b0;
        end else begin
            width_q <= width_d;
            valid_q <= valid_d;
        end
    end

    assign bus.width_out = width_q;
    assign bus.valid     = valid_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.evt_cnt  = evt_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == S_QUAL) || (state_q == S_MEAS) || (state_q == S_HOLDOFF);
endmodule
